// File: rtl/bram_port_arbiter_pkg.sv
// rtl/bram_port_arbiter_pkg.sv - shared types and sizing helpers for the BRAM port arbiter
package bram_arb_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  localparam int LOCK_CNT_W = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_picker.sv
// rtl/bram_port_arbiter_rr_picker.sv - combinational round-robin priority encoder
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin sharing of one BRAM port with bounded lock
module bram_port_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int BRAM_LATENCY = 0,
  parameter int LOCK_MAX     = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      bram_wren,
  output logic [ADDR_W-1:0]         bram_address,
  output logic [DATA_W-1:0]         bram_data,
  input  logic [DATA_W-1:0]         bram_q
);
  import bram_arb_pkg::*;

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t              state, state_n;
  logic [IDX_W-1:0]        rr, rr_n, owner, owner_n, sel;
  logic [LOCK_CNT_W-1:0]   lock_cnt, lock_cnt_n;
  logic [NUM_REQ-1:0]      owner_mask, cand, grant_vec, rd_vec;
  logic                    any_req, granted;
  logic [ADDR_W-1:0]       sel_addr, addr_hold;
  logic [DATA_W-1:0]       sel_data, data_hold;

  // While locked, only the owner is visible to the picker.
  assign owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign cand       = (state == LOCKED) ? (req & owner_mask) : req;

  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req   (cand),
    .start (rr),
    .grant (grant_vec),
    .idx   (sel),
    .any   (any_req)
  );

  // Reset also masks the combinational grant path so every output reads zero.
  assign granted  = any_req & reset_n;
  assign sel_addr = addr[int'(sel)*ADDR_W +: ADDR_W];
  assign sel_data = wdata[int'(sel)*DATA_W +: DATA_W];

  assign ack          = granted ? grant_vec : '0;
  assign bram_wren    = granted & we[sel];
  assign bram_address = granted ? sel_addr : addr_hold;
  assign bram_data    = granted ? sel_data : data_hold;
  assign rd_vec       = (granted && !we[sel]) ? grant_vec : '0;

  generate
    if (BRAM_LATENCY == 0) begin : g_comb
      assign rvalid = rd_vec;
    end else begin : g_reg
      logic [NUM_REQ-1:0] rvalid_q;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rvalid_q <= '0;
        else          rvalid_q <= rd_vec;
      end
      assign rvalid = rvalid_q;
    end
  endgenerate

  assign rdata = (|rvalid) ? bram_q : '0;

  always_comb begin
    state_n    = state;
    rr_n       = rr;
    owner_n    = owner;
    lock_cnt_n = lock_cnt;
    if (granted) rr_n = (sel == IDX_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
    case (state)
      ARB: begin
        if (granted && lock[sel] && LOCK_MAX > 1) begin
          state_n    = LOCKED;
          owner_n    = sel;
          lock_cnt_n = LOCK_CNT_W'(1);
        end
      end
      LOCKED: begin
        // Stalled owner cycles count too, so the lock is always bounded.
        lock_cnt_n = lock_cnt + 1'b1;
        if ((granted && !lock[sel]) || lock_cnt_n == LOCK_CNT_W'(LOCK_MAX)) begin
          state_n    = ARB;
          lock_cnt_n = '0;
        end
      end
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      rr        <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      state    <= state_n;
      rr       <= rr_n;
      owner    <= owner_n;
      lock_cnt <= lock_cnt_n;
      if (granted) begin
        addr_hold <= sel_addr;
        data_hold <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req = '0, we = '0, lock = '0;
  logic [AW-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;

  logic [N-1:0]  ack1, rvalid1, ack0, rvalid0;
  logic [DW-1:0] rdata1, rdata0, bdata1, bdata0, q1, q0;
  logic          wren1, wren0;
  logic [AW-1:0] baddr1, baddr0;
  logic [DW-1:0] mem1 [0:1023];
  logic [DW-1:0] mem0 [0:1023];

  int errors = 0;
  int checks = 0;
  int a_tab [3];

  assign addr  = {a2, a1, a0};
  assign wdata = {d2, d1, d0};

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] f(input int a);
    return DW'(a * 3 + 1);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] <= f(i);
      mem0[i] <= f(i);
    end
  end

  always @(posedge clock) begin
    if (wren1) mem1[baddr1] <= bdata1;
    q1 <= mem1[baddr1];
    if (wren0) mem0[baddr0] <= bdata0;
  end
  assign q0 = mem0[baddr0];

  bram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BRAM_LATENCY(1), .LOCK_MAX(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .ack(ack1), .rvalid(rvalid1), .rdata(rdata1), .bram_wren(wren1), .bram_address(baddr1),
    .bram_data(bdata1), .bram_q(q1));

  bram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BRAM_LATENCY(0), .LOCK_MAX(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .ack(ack0), .rvalid(rvalid0), .rdata(rdata0), .bram_wren(wren0), .bram_address(baddr0),
    .bram_data(bdata0), .bram_q(q0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    a_tab = '{'h010, 'h020, 'h3FF};

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ack", 32'(ack1), 0);
    chk("rst_rvalid", 32'(rvalid1), 0);
    chk("rst_rdata", 32'(rdata1), 0);
    chk("rst_wren", 32'(wren1), 0);
    chk("rst_addr", 32'(baddr1), 0);
    chk("rst_data", 32'(bdata1), 0);
    next_cycle();
    reset_n = 1'b1;

    // all requesters reading continuously, registered RAM
    req = 3'b111; we = '0; lock = '0;
    a0 = 10'h010; a1 = 10'h020; a2 = 10'h3FF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("rr_ack", 32'(ack1), 32'(1) << (c % 3));
      chk("rr_addr", 32'(baddr1), 32'(a_tab[c % 3]));
      if (c == 0) begin
        chk("rr_rvalid0", 32'(rvalid1), 0);
      end else begin
        chk("rr_rvalid", 32'(rvalid1), 32'(1) << ((c - 1) % 3));
        chk("rr_rdata", 32'(rdata1), 32'(f(a_tab[(c - 1) % 3])));
      end
      next_cycle();
    end

    // idle: last read still returns, port holds last address
    req = '0;
    @(negedge clock);
    chk("idle_ack", 32'(ack1), 0);
    chk("idle_rvalid", 32'(rvalid1), 32'b001);
    chk("idle_rdata", 32'(rdata1), 32'(f('h010)));
    chk("idle_wren", 32'(wren1), 0);
    chk("idle_addr_hold", 32'(baddr1), 32'h010);
    next_cycle();

    // requester 1 writes 0xA5 to 0x3FF, then requester 2 reads it back
    req = 3'b010; we = 3'b010; a1 = 10'h3FF; d1 = 8'hA5;
    @(negedge clock);
    chk("wr_ack", 32'(ack1), 32'b010);
    chk("wr_wren", 32'(wren1), 1);
    chk("wr_addr", 32'(baddr1), 32'h3FF);
    chk("wr_data", 32'(bdata1), 32'hA5);
    next_cycle();
    req = 3'b100; we = '0; a2 = 10'h3FF;
    @(negedge clock);
    chk("rd_ack", 32'(ack1), 32'b100);
    chk("wr_no_rvalid", 32'(rvalid1), 0);
    next_cycle();
    req = '0;
    @(negedge clock);
    chk("rd_rvalid", 32'(rvalid1), 32'b100);
    chk("rd_rdata", 32'(rdata1), 32'hA5);
    next_cycle();

    // requester 0 locks with requester 1 waiting: four acks then forced release
    req = 3'b011; lock = 3'b001; a0 = 10'h010; a1 = 10'h020;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("lock_ack", 32'(ack1), 32'b001);
      if (c == 1) chk("lock_rvalid", 32'(rvalid1), 32'b001);
      next_cycle();
    end
    @(negedge clock);
    chk("lock_release_ack", 32'(ack1), 32'b010);
    next_cycle();

    // owner stalls for two cycles inside the lock
    @(negedge clock);
    chk("stall_lock_ack", 32'(ack1), 32'b001);
    next_cycle();
    req = 3'b010;
    @(negedge clock);
    chk("stall_ack_a", 32'(ack1), 0);
    next_cycle();
    @(negedge clock);
    chk("stall_ack_b", 32'(ack1), 0);
    chk("stall_rvalid", 32'(rvalid1), 0);
    next_cycle();
    req = 3'b011;
    @(negedge clock);
    chk("stall_last_ack", 32'(ack1), 32'b001);
    next_cycle();
    req = 3'b010;
    @(negedge clock);
    chk("stall_release_ack", 32'(ack1), 32'b010);
    next_cycle();

    // reset during a pending registered read
    req = 3'b100; lock = '0; a2 = 10'h3FF;
    @(negedge clock);
    chk("pre_rst_ack", 32'(ack1), 32'b100);
    next_cycle();
    reset_n = 1'b0; req = 3'b111;
    #1;
    chk("midrst_rvalid", 32'(rvalid1), 0);
    chk("midrst_ack", 32'(ack1), 0);
    chk("midrst_rdata", 32'(rdata1), 0);
    chk("midrst_addr", 32'(baddr1), 0);
    chk("midrst_data", 32'(bdata1), 0);
    chk("midrst_wren", 32'(wren1), 0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clock);
    chk("postrst_ack", 32'(ack1), 32'b001);
    chk("postrst_rvalid", 32'(rvalid1), 0);
    next_cycle();

    // combinational RAM: rvalid with ack in the same cycle
    req = 3'b100;
    @(negedge clock);
    chk("lat0_ack", 32'(ack0), 32'b100);
    chk("lat0_rvalid", 32'(rvalid0), 32'b100);
    chk("lat0_rdata", 32'(rdata0), 32'hA5);
    next_cycle();
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares one port of the dual-port block RAM between NUM_REQ requesters (e.g. CPU shadow writes, DMA, debug/ROM loader) on a single clock. Round-robin arbitration, one access per cycle, with an optional bounded lock for read-modify-write sequences. Returns read data tagged to the requester, aligned to the RAM's configured read latency (combinational or registered).

## Interface
Parameters:
- NUM_REQ, 3: number of requesters, 2..8.
- ADDR_W, 10: RAM address width; matches the RAM's widthad_a.
- DATA_W, 8: RAM data width; matches the RAM's width_a.
- BRAM_LATENCY, 0: RAM port read latency; 0 means combinational, 1 means registered. Must equal the attached RAM's setting.
- LOCK_MAX, 16: maximum consecutive grants a locking requester may hold, 1..255.

Ports:
- clock  in  1  single clock for all logic. The attached RAM port clock is tied to it.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester access request; held until ack.
- we  in  NUM_REQ  per-requester write enable, qualified by req.
- lock  in  NUM_REQ  keep the grant after this access.
- addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  flattened write data.
- ack  out  NUM_REQ  one-hot; access accepted this cycle.
- rvalid  out  NUM_REQ  one-hot; read data valid for requester i.
- rdata  out  DATA_W  shared read data; qualified by rvalid.
- bram_wren  out  1  RAM port write enable.
- bram_address  out  ADDR_W  RAM port address.
- bram_data  out  DATA_W  RAM port write data.
- bram_q  in  DATA_W  RAM port read data.

## Operation
- FSM, two states:
  - ARB: a round-robin search starts at pointer rr and selects the first requester with req=1. The selection drives the RAM port and asserts ack[sel]. rr moves to sel+1 and wraps from NUM_REQ-1 to 0.
    - If lock[sel]=1, go to LOCKED with owner=sel and lock_cnt=1.
  - LOCKED: only the owner can be granted. Other requests wait with no ack.
    - Each owner access increments lock_cnt.
    - The FSM returns to ARB when the owner's accepted access has lock=0, or when lock_cnt reaches LOCK_MAX (forced release).
    - Owner req=0 while in LOCKED: no access that cycle, and the FSM stays LOCKED. The cycle still counts toward lock_cnt, so a stalled owner cannot starve others.
- RAM port outputs are combinational from the selection. When no access is granted: bram_wren=0, and address and data hold their last granted values.
- Reads: rvalid[sel] is asserted per BRAM_LATENCY and rdata=bram_q.
- Writes: ack only. rvalid is never asserted for a write.
- Requester contract: req, we, addr, wdata and lock stay stable until ack. Dropping req before ack cancels the request; this is legal.

## Timing
- Throughput: one access per cycle.
- A request sampled with req=1 in ARB gets ack in the same cycle when it is first in round-robin order. Worst-case wait is NUM_REQ-1 cycles, excluding locks. Worst case with locks: (NUM_REQ-1)*LOCK_MAX cycles.
- BRAM_LATENCY=0: rvalid is in the same cycle as ack.
- BRAM_LATENCY=1: rvalid is one cycle after ack. The tag and valid are held in a one-stage register.
- Back-to-back reads from different requesters: rvalid tags follow ack order exactly, one per cycle.
- Reset values:
  - ack=0, rvalid=0, rdata=0.
  - bram_wren=0, bram_address=0, bram_data=0.
  - rr=0, state=ARB, lock_cnt=0.
- Reset asserted mid-read: the pending rvalid is discarded. The first access after reset release is granted to the lowest index with req=1.

## Structure
- Package bram_arb_pkg holds:
  - typedef enum {ARB, LOCKED} arb_state_t;
  - localparam IDX_W = $clog2(NUM_REQ) helper function.
  - lock counter width constant (8 bits).
- Sub-module rr_picker: combinational round-robin priority encoder. Inputs are the request vector and the start pointer; outputs are the one-hot grant and the index.

## Test plan
- NUM_REQ=3, all req=1 continuously as reads, LATENCY=1 -> ack order 0,1,2,0,… one per cycle, rvalid trails ack by one cycle with matching tag, rdata equals preloaded mem[addr].
- Requester 1 writes 0xA5 to 0x3FF; in the next cycle requester 2 reads 0x3FF -> ack1 then ack2, rvalid[2] carries 0xA5; address wrap at 0x3FF is correct.
- Requester 0 locked with LOCK_MAX=4 while req1 is waiting -> 4 consecutive acks to 0, forced release, ack1 on the next cycle.
- Owner in LOCKED drops req for 2 cycles -> no ack to anyone, lock_cnt still advances, release occurs at LOCK_MAX.
- reset_n pulsed low during a pending read with LATENCY=1 -> rvalid=0 and all outputs zero immediately; after release, lowest-index requester is granted first.
- LATENCY=0 read by requester 2 -> ack[2] and rvalid[2] asserted in the same cycle, rdata=bram_q.
